// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequenced 16x16 Vedic multiplier.
// Holds the FSM state enum, step counter type, widths and per-step shifts.
package vedic_pkg;

    localparam int DIGIT_W = 8;
    localparam int OP_W    = 16;
    localparam int PROD_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    typedef logic [1:0] step_t;

    // Partial-product weights: lo*lo, lo*hi, hi*lo, hi*hi.
    localparam logic [4:0] SHIFT_AMT [0:3] = '{5'd0, 5'd8, 5'd8, 5'd16};

endpackage

// File: rtl/vedic_8X8.sv
// Combinational 8x8 unsigned multiplier built Urdhva-style from four 4x4
// sub-products combined with vertical/crosswise weighting.
module vedic_8X8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
        return {4'd0, x} * {4'd0, y};
    endfunction

    logic [7:0] ll_s;
    logic [7:0] lh_s;
    logic [7:0] hl_s;
    logic [7:0] hh_s;

    assign ll_s = mul4(a[3:0], b[3:0]);
    assign lh_s = mul4(a[3:0], b[7:4]);
    assign hl_s = mul4(a[7:4], b[3:0]);
    assign hh_s = mul4(a[7:4], b[7:4]);

    assign p = {8'd0, ll_s}
             + ({8'd0, lh_s} << 4)
             + ({8'd0, hl_s} << 4)
             + ({8'd0, hh_s} << 8);

endmodule

// File: rtl/vedic_mul16_seq.sv
// 16x16 unsigned multiplier that time-shares one vedic_8X8 core over four
// steps, with valid/ready handshakes on operands and product.
module vedic_mul16_seq
    import vedic_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PROD_W-1:0]   p,
    output logic                busy
);

    mul_state_t          state_r;
    mul_state_t          next_s;
    step_t               step_r;
    logic [OP_W-1:0]     a_q_r;
    logic [OP_W-1:0]     b_q_r;
    logic [PROD_W-1:0]   acc_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                busy_r;
    logic [DIGIT_W-1:0]  core_a_s;
    logic [DIGIT_W-1:0]  core_b_s;
    logic [2*DIGIT_W-1:0] pp_s;
    logic [PROD_W-1:0]   pp_shifted_s;

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) next_s = MUL;
                else          next_s = IDLE;
            end
            MUL: begin
                if (step_r == 2'd3) next_s = DONE;
                else                next_s = MUL;
            end
            DONE: begin
                if (out_ready) next_s = IDLE;
                else           next_s = DONE;
            end
            default: next_s = IDLE;
        endcase
    end

    // Byte-pair select for the shared core
    always_comb begin
        core_a_s = a_q_r[7:0];
        core_b_s = b_q_r[7:0];
        case (step_r)
            2'd0: begin core_a_s = a_q_r[7:0];  core_b_s = b_q_r[7:0];  end
            2'd1: begin core_a_s = a_q_r[7:0];  core_b_s = b_q_r[15:8]; end
            2'd2: begin core_a_s = a_q_r[15:8]; core_b_s = b_q_r[7:0];  end
            2'd3: begin core_a_s = a_q_r[15:8]; core_b_s = b_q_r[15:8]; end
            default: begin core_a_s = 8'd0; core_b_s = 8'd0; end
        endcase
    end

    vedic_8X8 u_core (
        .a (core_a_s),
        .b (core_b_s),
        .p (pp_s)
    );

    assign pp_shifted_s = {16'd0, pp_s} << SHIFT_AMT[step_r];

    // State, operand, accumulator and step registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            step_r  <= 2'd0;
            a_q_r   <= 16'd0;
            b_q_r   <= 16'd0;
            acc_r   <= 32'd0;
        end else begin
            state_r <= next_s;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_q_r  <= a;
                        b_q_r  <= b;
                        acc_r  <= 32'd0;
                        step_r <= 2'd0;
                    end
                end
                MUL: begin
                    acc_r  <= acc_r + pp_shifted_s;
                    step_r <= step_r + 2'd1;
                end
                DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    step_r <= 2'd0;
                end
            endcase
        end
    end

    // Handshake/status flags registered from the next state, so no input
    // reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (next_s == IDLE);
            out_valid_r <= (next_s == DONE);
            busy_r      <= (next_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign p         = acc_r;

endmodule
